noc_boot_loader: RTL and testbench
==================================

Name: noc_boot_loader

Overview:
- Synthesizable front-end that initializes every tile memory in the 3x3 NoC `system` and then releases the tiles from reset.
- Accepts a byte stream on a valid/ready interface and assembles four bytes per address: starting-tile instruction, starting-tile data, internal-tile instruction, internal-tile data.
- Drives `init_mem`, `address`, and the instruction/data write bytes into `system`: tile 0 gets the starting image, tiles 1-8 share the broadcast internal image.
- Releases the active-low `rst_n` of `system` once the last address is written.

Parameters:
- MEM_BYTES, 256, number of byte addresses loaded per memory (addresses 0..MEM_BYTES-1).
- ADDR_W, 8, width of `address`; MEM_BYTES <= 2**ADDR_W.
- RELEASE_DELAY, 4, cycles `sys_rst_n` stays low after the last write.
- TIMEOUT, 1024, idle cycles in LOAD without an accepted byte before ERROR.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load.
- src_valid  in  1  byte-stream valid.
- src_data  in  8  byte-stream data.
- src_ready  out  1  loader accepts a byte this cycle when src_valid&src_ready.
- init_mem  out  1  memory-init window to `system`.
- wr_en  out  1  one-cycle write strobe for the current address.
- address  out  ADDR_W  byte address being written.
- inst0  out  8  starting-tile instruction byte.
- data0  out  8  starting-tile data byte.
- inst_int  out  8  internal-tile instruction byte (tiles 1-8).
- data_int  out  8  internal-tile data byte (tiles 1-8).
- sys_rst_n  out  1  active-low reset to `system`.
- busy  out  1  high in LOAD, WRITE and RELEASE.
- done  out  1  load completed and tiles released.
- error  out  1  source timeout occurred.

Behaviour:
- Reset, synchronous with rst=1:
  - state=IDLE; all outputs 0, including sys_rst_n=0, so tiles are held in reset.
  - Internal byte index, address and timeout counter cleared.
- States: IDLE, LOAD, WRITE, RELEASE, DONE, ERROR.
- IDLE:
  - src_ready=0, init_mem=0.
  - start -> LOAD with address=0, byte index=0, sys_rst_n=0, done=0, error=0.
- LOAD:
  - init_mem=1, src_ready=1.
  - Each accepted byte goes into slot (index): 0=inst0, 1=data0, 2=inst_int, 3=data_int. The index then increments and the timeout counter clears.
  - On acceptance of slot 3 -> WRITE on the next cycle.
  - Output byte registers update only on acceptance; address holds.
- WRITE:
  - Exactly one cycle: wr_en=1, src_ready=0, address and all four bytes stable and valid.
  - If address==MEM_BYTES-1 -> RELEASE; else address+1, index=0 -> LOAD.
  - Write latency: wr_en is asserted the cycle after the 4th byte handshake.
- RELEASE:
  - init_mem=0, wr_en=0.
  - Counts RELEASE_DELAY cycles with sys_rst_n=0, then sets sys_rst_n=1, done=1 -> DONE.
  - First cycle with sys_rst_n=1 is RELEASE entry + RELEASE_DELAY.
- DONE:
  - sys_rst_n=1, done=1, busy=0.
  - start restarts the load: same cycle transition to LOAD, sys_rst_n->0 and done->0 on the next edge, address=0.
- Timeout:
  - In LOAD, the counter increments every cycle with no accepted byte.
  - When it reaches TIMEOUT-1 -> ERROR with error=1, init_mem=0, sys_rst_n=0.
  - Partial bytes are discarded.
- ERROR:
  - Holds until start, which restarts from address 0 and clears error, or until rst.
- start while busy is ignored.
- A byte presented while src_ready=0 is not consumed; the source must hold it.
- src_data is sampled only on the handshake edge.
- rst mid-operation: immediate return to IDLE on that edge; sys_rst_n=0 regardless of prior state.
- address never exceeds MEM_BYTES-1; no wrap to 0 inside one load.

Test Plan:
- Full load, src_valid always 1, bytes = index mod 256:
  - exactly 256 wr_en pulses, one every 5 cycles.
  - At address 0x05: inst0=0x14, data0=0x15, inst_int=0x16, data_int=0x17.
  - sys_rst_n rises 4 cycles after the last WRITE; done=1.
- Source stalls: src_valid toggled 1/0 each cycle:
  - bytes assembled in correct slots, no byte lost or duplicated.
  - wr_en spacing 8-9 cycles; final image identical to scenario 1.
- Timeout: stop src_valid after 2 bytes at address 0x10, TIMEOUT=1024:
  - ERROR reached 1023 cycles later; error=1, init_mem=0, sys_rst_n=0.
  - start then reloads from address 0.
- Reset mid-load at address 0x80:
  - next edge: state IDLE, all outputs 0.
  - Following start reloads from address 0 with correct data.
- start pulses during LOAD and RELEASE are ignored, with no address reset.
- start in DONE: sys_rst_n drops the next cycle and a second full load completes.
- MEM_BYTES=4, RELEASE_DELAY=1: exactly 4 writes at addresses 0..3, then sys_rst_n=1 one cycle after the RELEASE entry.

Source files
------------

// File: rtl/noc_boot_loader.sv
// Boot loader for the 3x3 NoC: assembles four bytes per address from a byte stream,
// writes tile 0 and the broadcast internal image, then releases the tiles from reset.
module noc_boot_loader #(
  parameter int MEM_BYTES     = 256,
  parameter int ADDR_W        = 8,
  parameter int RELEASE_DELAY = 4,
  parameter int TIMEOUT       = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              src_valid,
  input  logic [7:0]        src_data,
  output logic              src_ready,
  output logic              init_mem,
  output logic              wr_en,
  output logic [ADDR_W-1:0] address,
  output logic [7:0]        inst0,
  output logic [7:0]        data0,
  output logic [7:0]        inst_int,
  output logic [7:0]        data_int,
  output logic              sys_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // state   | meaning
  // IDLE    | after reset, tiles held in reset, waiting for start
  // LOAD    | collecting the four bytes of the current address
  // WRITE   | one-cycle write strobe for the current address
  // RELEASE | all addresses written, holding tile reset for RELEASE_DELAY cycles
  // DONE    | tiles released, start reloads
  // ERROR   | source timed out, start reloads
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    WRITE   = 3'd2,
    RELEASE = 3'd3,
    DONE    = 3'd4,
    ERROR   = 3'd5
  } state_t;

  localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int RD_W = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 2);
  localparam logic [RD_W-1:0]   RD_LOAD   = RD_W'(RELEASE_DELAY - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEM_BYTES - 1);

  state_t            state, state_nxt;
  logic [1:0]        idx;
  logic [TO_W-1:0]   to_cnt;
  logic [RD_W-1:0]   rel_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        inst0_q, data0_q, inst_int_q, data_int_q;
  logic              sys_rst_n_q, done_q, error_q;
  logic              accept, last_addr, to_expire, rel_expire;

  assign accept     = (state == LOAD) && src_valid;
  assign last_addr  = (addr_q == ADDR_LAST);
  assign to_expire  = (to_cnt == TO_LAST);
  assign rel_expire = (rel_cnt == '0);

  always_comb begin
    state_nxt = state;
    src_ready = 1'b0;
    init_mem  = 1'b0;
    wr_en     = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        src_ready = 1'b1;
        init_mem  = 1'b1;
        busy      = 1'b1;
        if (accept && idx == 2'd3) state_nxt = WRITE;
        else if (!accept && to_expire) state_nxt = ERROR;
      end
      WRITE: begin
        init_mem  = 1'b1;
        wr_en     = 1'b1;
        busy      = 1'b1;
        state_nxt = last_addr ? RELEASE : LOAD;
      end
      RELEASE: begin
        busy = 1'b1;
        if (rel_expire) state_nxt = DONE;
      end
      DONE, ERROR: begin
        if (start) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      to_cnt      <= '0;
      rel_cnt     <= '0;
      addr_q      <= '0;
      inst0_q     <= '0;
      data0_q     <= '0;
      inst_int_q  <= '0;
      data_int_q  <= '0;
      sys_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            addr_q      <= '0;
            idx         <= '0;
            to_cnt      <= '0;
            sys_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            case (idx)
              2'd0:    inst0_q    <= src_data;
              2'd1:    data0_q    <= src_data;
              2'd2:    inst_int_q <= src_data;
              default: data_int_q <= src_data;
            endcase
            idx    <= idx + 2'd1;
            to_cnt <= '0;
          end else if (to_expire) begin
            error_q <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WRITE: begin
          if (last_addr) begin
            rel_cnt <= RD_LOAD;
          end else begin
            addr_q <= addr_q + 1'b1;
            idx    <= '0;
          end
        end
        RELEASE: begin
          if (rel_expire) begin
            sys_rst_n_q <= 1'b1;
            done_q      <= 1'b1;
          end else begin
            rel_cnt <= rel_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign address   = addr_q;
  assign inst0     = inst0_q;
  assign data0     = data0_q;
  assign inst_int  = inst_int_q;
  assign data_int  = data_int_q;
  assign sys_rst_n = sys_rst_n_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_noc_boot_loader.sv
// Directed bench for noc_boot_loader: full loads, stalls, timeout, reset, restarts,
// plus a 4-byte instance with a one-cycle release delay.
module tb_noc_boot_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       src_valid = 1'b0;
  logic [7:0] src_data = 8'h00;
  logic       src_ready, init_mem, wr_en, sys_rst_n, busy, done, error;
  logic [7:0] address, inst0, data0, inst_int, data_int;

  logic       s_start = 1'b0;
  logic       s_src_valid = 1'b0;
  logic [7:0] s_src_data = 8'h00;
  logic       s_src_ready, s_init_mem, s_wr_en, s_sys_rst_n, s_busy, s_done, s_error;
  logic [1:0] s_address;
  logic [7:0] s_inst0, s_data0, s_inst_int, s_data_int;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  noc_boot_loader dut (
    .clk(clk), .rst(rst), .start(start), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .init_mem(init_mem), .wr_en(wr_en), .address(address),
    .inst0(inst0), .data0(data0), .inst_int(inst_int), .data_int(data_int),
    .sys_rst_n(sys_rst_n), .busy(busy), .done(done), .error(error)
  );

  noc_boot_loader #(.MEM_BYTES(4), .ADDR_W(2), .RELEASE_DELAY(1), .TIMEOUT(1024)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .src_valid(s_src_valid), .src_data(s_src_data),
    .src_ready(s_src_ready), .init_mem(s_init_mem), .wr_en(s_wr_en), .address(s_address),
    .inst0(s_inst0), .data0(s_data0), .inst_int(s_inst_int), .data_int(s_data_int),
    .sys_rst_n(s_sys_rst_n), .busy(s_busy), .done(s_done), .error(s_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // write capture for the 256-byte instance
  logic [31:0] img [256];
  int wr_cnt, last_wr, min_sp, max_sp, rel_entry, rise;
  bit prev_rn = 1'b0;

  always @(negedge clk) begin
    if (wr_en) begin
      img[address] = {inst0, data0, inst_int, data_int};
      if (wr_cnt > 0) begin
        if (cyc - last_wr < min_sp) min_sp = cyc - last_wr;
        if (cyc - last_wr > max_sp) max_sp = cyc - last_wr;
      end
      last_wr = cyc;
      wr_cnt++;
    end
    if (busy && !init_mem && rel_entry < 0) rel_entry = cyc;
    if (sys_rst_n && !prev_rn) rise = cyc;
    prev_rn = sys_rst_n;
  end

  task automatic clear_mon();
    wr_cnt = 0; last_wr = 0; min_sp = 1000000; max_sp = 0; rel_entry = -1; rise = -1;
    for (int a = 0; a < 256; a++) img[a] = 32'hA5A5A5A5;
  endtask

  function automatic int image_bad();
    int bad = 0;
    for (int a = 0; a < 256; a++) begin
      logic [7:0] b;
      b = 8'(4 * a);
      if (img[a] !== {b, b + 8'd1, b + 8'd2, b + 8'd3}) bad++;
    end
    return bad;
  endfunction

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Byte source: byte k carries value k mod 256. Stops at done or after stop_k bytes.
  task automatic feed(input bit toggle, input int stop_k, input int poke_addr,
                      input bit poke_rel, output int addr_after, output bit ok);
    int k = 0;
    bit hs = 1'b0, ph = 1'b0, poked = 1'b0, got = 1'b0, poked_rel = 1'b0;
    ok = 1'b0;
    addr_after = -1;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (hs) k++;
      if (poked && !got) begin addr_after = int'(address); got = 1'b1; end
      if (done) begin ok = 1'b1; break; end
      if (k >= stop_k) begin ok = 1'b1; break; end
      if (poke_addr >= 0 && !poked && src_ready && int'(address) == poke_addr) begin
        start = 1'b1; poked = 1'b1;
      end
      if (poke_rel && !poked_rel && busy && !init_mem) begin start = 1'b1; poked_rel = 1'b1; end
      ph = ~ph;
      src_valid = toggle ? ph : 1'b1;
      src_data = 8'(k);
      hs = src_valid && src_ready;
    end
    src_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({src_ready, init_mem, wr_en} !== 3'b000) begin errors++;
      $display("FAIL reset_ctrl: got %b want 000", {src_ready, init_mem, wr_en}); end
    checks++; if ({busy, done, error, sys_rst_n} !== 4'b0000) begin errors++;
      $display("FAIL reset_status: got %b want 0000", {busy, done, error, sys_rst_n}); end
    checks++; if ({address, inst0, data0, inst_int, data_int} !== 40'h0) begin errors++;
      $display("FAIL reset_data: got %h want 0", {address, inst0, data0, inst_int, data_int}); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({busy, src_ready, sys_rst_n} !== 3'b000) begin errors++;
      $display("FAIL idle_hold: got %b want 000", {busy, src_ready, sys_rst_n}); end
  endtask

  task automatic test_full_load();
    int aa; bit ok;
    clear_mon();
    pulse_start();
    checks++; if ({busy, init_mem, src_ready, sys_rst_n} !== 4'b1110) begin errors++;
      $display("FAIL load_entry: got %b want 1110", {busy, init_mem, src_ready, sys_rst_n}); end
    feed(1'b0, 100000, -1, 1'b0, aa, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_timeout: done not reached"); end
    checks++; if (wr_cnt !== 256) begin errors++;
      $display("FAIL full_wr_count: got %0d want 256", wr_cnt); end
    checks++; if (min_sp !== 5 || max_sp !== 5) begin errors++;
      $display("FAIL full_spacing: got %0d..%0d want 5..5", min_sp, max_sp); end
    checks++; if (img[5] !== 32'h14151617) begin errors++;
      $display("FAIL full_addr5: got %h want 14151617", img[5]); end
    checks++; if (image_bad() !== 0) begin errors++;
      $display("FAIL full_image: %0d bad addresses want 0", image_bad()); end
    checks++; if (rise - rel_entry !== 4 || rel_entry - last_wr !== 1) begin errors++;
      $display("FAIL full_release: rise-entry %0d entry-wr %0d want 4 and 1",
               rise - rel_entry, rel_entry - last_wr); end
    checks++; if ({done, sys_rst_n, busy, init_mem} !== 4'b1100) begin errors++;
      $display("FAIL full_done: got %b want 1100", {done, sys_rst_n, busy, init_mem}); end
  endtask

  task automatic test_stall();
    int aa; bit ok;
    clear_mon();
    pulse_start();
    feed(1'b1, 100000, -1, 1'b0, aa, ok);
    checks++; if (!ok || wr_cnt !== 256) begin errors++;
      $display("FAIL stall_wr_count: got %0d want 256", wr_cnt); end
    checks++; if (min_sp < 8 || max_sp > 9) begin errors++;
      $display("FAIL stall_spacing: got %0d..%0d want within 8..9", min_sp, max_sp); end
    checks++; if (image_bad() !== 0) begin errors++;
      $display("FAIL stall_image: %0d bad addresses want 0", image_bad()); end
    checks++; if (done !== 1'b1 || sys_rst_n !== 1'b1) begin errors++;
      $display("FAIL stall_done: got %b%b want 11", done, sys_rst_n); end
  endtask

  task automatic test_back_to_back();
    int aa; bit ok;
    clear_mon();
    pulse_start();
    checks++; if ({sys_rst_n, done, busy, address} !== {3'b001, 8'h00}) begin errors++;
      $display("FAIL restart_done: got %b/%h want 001/00", {sys_rst_n, done, busy}, address); end
    feed(1'b0, 100000, 8'h30, 1'b1, aa, ok);
    checks++; if (aa !== 32'h30) begin errors++;
      $display("FAIL start_in_load: address after pulse %h want 30", aa); end
    checks++; if (!ok || wr_cnt !== 256) begin errors++;
      $display("FAIL restart_wr_count: got %0d want 256", wr_cnt); end
    checks++; if (rise - rel_entry !== 4) begin errors++;
      $display("FAIL start_in_release: rise-entry %0d want 4", rise - rel_entry); end
    checks++; if (image_bad() !== 0 || done !== 1'b1) begin errors++;
      $display("FAIL restart_image: bad %0d done %b want 0 and 1", image_bad(), done); end
  endtask

  task automatic test_timeout();
    int aa, j; bit ok;
    clear_mon();
    pulse_start();
    feed(1'b0, 8'h10 * 4 + 2, -1, 1'b0, aa, ok);
    checks++; if (address !== 8'h10) begin errors++;
      $display("FAIL to_address: got %h want 10", address); end
    for (j = 2; j <= 1200; j++) begin
      @(negedge clk);
      if (error) break;
    end
    checks++; if (j !== 1024) begin errors++;
      $display("FAIL to_latency: error seen %0d cycles after last byte want 1024", j); end
    checks++; if ({error, init_mem, sys_rst_n, busy, src_ready} !== 5'b10000) begin errors++;
      $display("FAIL to_outputs: got %b want 10000", {error, init_mem, sys_rst_n, busy, src_ready}); end
    clear_mon();
    pulse_start();
    checks++; if ({error, address, busy} !== {1'b0, 8'h00, 1'b1}) begin errors++;
      $display("FAIL to_restart: err %b addr %h busy %b want 0/00/1", error, address, busy); end
    feed(1'b0, 100000, -1, 1'b0, aa, ok);
    checks++; if (!ok || wr_cnt !== 256 || image_bad() !== 0) begin errors++;
      $display("FAIL to_reload: writes %0d bad %0d want 256 and 0", wr_cnt, image_bad()); end
  endtask

  task automatic test_reset_mid_load();
    int aa; bit ok;
    clear_mon();
    pulse_start();
    feed(1'b0, 8'h80 * 4 + 1, -1, 1'b0, aa, ok);
    checks++; if (address !== 8'h80 || inst0 !== 8'h00 || data_int !== 8'hFF) begin errors++;
      $display("FAIL mid_before: addr %h inst0 %h data_int %h want 80/00/ff", address, inst0, data_int); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({src_ready, init_mem, wr_en, busy, done, error, sys_rst_n} !== 7'b0) begin errors++;
      $display("FAIL mid_rst_ctrl: got %b want 0000000",
               {src_ready, init_mem, wr_en, busy, done, error, sys_rst_n}); end
    checks++; if ({address, inst0, data0, inst_int, data_int} !== 40'h0) begin errors++;
      $display("FAIL mid_rst_data: got %h want 0", {address, inst0, data0, inst_int, data_int}); end
    @(negedge clk); rst = 1'b0;
    clear_mon();
    pulse_start();
    feed(1'b0, 100000, -1, 1'b0, aa, ok);
    checks++; if (!ok || wr_cnt !== 256 || image_bad() !== 0 || done !== 1'b1) begin errors++;
      $display("FAIL mid_reload: writes %0d bad %0d done %b want 256/0/1", wr_cnt, image_bad(), done); end
  endtask

  task automatic test_small();
    int k = 0, nw = 0, entry = -1, rs = -1;
    bit hs = 1'b0, seq_ok = 1'b1;
    logic [31:0] last_img = '0;
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (hs) k++;
      if (s_wr_en) begin
        if (int'(s_address) != nw) seq_ok = 1'b0;
        last_img = {s_inst0, s_data0, s_inst_int, s_data_int};
        nw++;
      end
      if (s_busy && !s_init_mem && entry < 0) entry = cyc;
      if (s_sys_rst_n && rs < 0) rs = cyc;
      if (s_done) break;
      s_src_valid = 1'b1;
      s_src_data = 8'(k);
      hs = s_src_ready;
    end
    s_src_valid = 1'b0;
    checks++; if (nw !== 4 || !seq_ok) begin errors++;
      $display("FAIL small_writes: got %0d in-order %b want 4 and 1", nw, seq_ok); end
    checks++; if (last_img !== 32'h0C0D0E0F) begin errors++;
      $display("FAIL small_last: got %h want 0c0d0e0f", last_img); end
    checks++; if (entry < 0 || rs - entry !== 1) begin errors++;
      $display("FAIL small_release: rise-entry %0d want 1", rs - entry); end
    checks++; if ({s_done, s_sys_rst_n, s_busy} !== 3'b110) begin errors++;
      $display("FAIL small_done: got %b want 110", {s_done, s_sys_rst_n, s_busy}); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_full_load();
    test_stall();
    test_back_to_back();
    test_timeout();
    test_reset_mid_load();
    test_small();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
